// File: rtl/clkdiv_inv_prog.sv
`default_nettype none
// ============================================================================
// Module   : clkdiv_inv_prog
// Desc     : Programmable clock divider with selectable output polarity.
//            Setting and start/stop changes take effect at period boundaries.
// Revision : 1.0 - initial release
// ============================================================================
module clkdiv_inv_prog #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] DIV,
    input  logic             INV,
    output logic             ZN,
    output logic             BUSY,
    output logic             PEND
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] C_DEF_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] C_MIN_DIV = WIDTH'(2);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic             inv_q, inv_d;
    logic [WIDTH-1:0] sh_n_q, sh_n_d;
    logic             sh_inv_q, sh_inv_d;
    logic             pend_q, pend_d;
    logic             zn_q, zn_d;

    logic [WIDTH-1:0] w_load_n;
    logic             w_wrap;

    // Ratios below 2 cannot produce both a high and a low phase.
    assign w_load_n = (DIV < C_MIN_DIV) ? C_MIN_DIV : DIV;
    assign w_wrap   = (cnt_q == (n_q - WIDTH'(1)));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            n_q      <= C_DEF_DIV;
            inv_q    <= 1'b0;
            sh_n_q   <= C_DEF_DIV;
            sh_inv_q <= 1'b0;
            pend_q   <= 1'b0;
            zn_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            n_q      <= n_d;
            inv_q    <= inv_d;
            sh_n_q   <= sh_n_d;
            sh_inv_q <= sh_inv_d;
            pend_q   <= pend_d;
            zn_q     <= zn_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        n_d      = n_q;
        inv_d    = inv_q;
        sh_n_d   = sh_n_q;
        sh_inv_d = sh_inv_q;
        pend_d   = pend_q;
        zn_d     = zn_q;

        case (state_q)
            IDLE: begin
                if (LOAD) begin
                    n_d      = w_load_n;
                    inv_d    = INV;
                    sh_n_d   = w_load_n;
                    sh_inv_d = INV;
                end
                cnt_d  = '0;
                pend_d = 1'b0;
                if (EN) begin
                    state_d = RUN;
                    zn_d    = ~inv_d;
                end else begin
                    zn_d = inv_d;
                end
            end
            RUN: begin
                if (w_wrap) begin
                    // A LOAD on the boundary edge supersedes any older shadow.
                    if (LOAD) begin
                        n_d      = w_load_n;
                        inv_d    = INV;
                        sh_n_d   = w_load_n;
                        sh_inv_d = INV;
                    end else if (pend_q) begin
                        n_d   = sh_n_q;
                        inv_d = sh_inv_q;
                    end
                    pend_d = 1'b0;
                    cnt_d  = '0;
                    if (!EN) begin
                        state_d = IDLE;
                        zn_d    = inv_d;
                    end else begin
                        zn_d = ~inv_d;
                    end
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                    if (LOAD) begin
                        sh_n_d   = w_load_n;
                        sh_inv_d = INV;
                        pend_d   = 1'b1;
                    end
                    zn_d = inv_q ^ (cnt_d < (n_q >> 1));
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ZN   = zn_q;
    assign BUSY = (state_q == RUN);
    assign PEND = pend_q;

endmodule
`default_nettype wire
